// File: rtl/fetch_pkg.sv
// Shared types for the decoupled fetch stage: one queued fetch entry and the instruction size.
package fetch_pkg;
  localparam int FETCH_XLEN  = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue with wrapping pointers, occupancy count and synchronous flush.
// Storage is left unreset; only the pointers and the count clear.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A full queue may still accept a push when the head pops in the same cycle.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
                    !(push_i && full_o && !pop_i && !flush_i));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                    !(pop_i && empty_o));
endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled fetch: credit-limited request issue, in-order response capture into a queue,
// and redirect handling that flushes the queue and squashes responses still in flight.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] PC_START        = 32'h8000_0000,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            E_redirect_valid,
  input  logic [XLEN-1:0] E_redirect_pc,
  output logic            F_valid,
  input  logic            F_ready,
  output logic [31:0]     F_instr,
  output logic [XLEN-1:0] F_pc_current,
  output logic [XLEN-1:0] F_pc_plus_4,
  output logic [XLEN-1:0] pc
);
  localparam int              OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int              CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic            run_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count;
  logic            credit_ok, fire, push, pop, q_empty, q_full;
  fetch_entry_t    wr_entry, rd_entry;

  // Counting queued entries plus in-flight reads guarantees every response has a slot.
  assign credit_ok = (int'(outstanding_q) < MAX_OUTSTANDING) &&
                     (int'(outstanding_q) + int'(count) < FIFO_DEPTH);

  assign imem_req_valid = run_q && !E_redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign pc             = fetch_pc_q;
  assign fire           = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && (drop_cnt_q == '0) && !E_redirect_valid;
  assign pop            = F_valid && F_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + OW'(fire) - OW'(imem_rsp_valid);
    if (E_redirect_valid) begin
      // Everything still in flight after this cycle's response belongs to the old path.
      fetch_pc_d = E_redirect_pc;
      rsp_pc_d   = E_redirect_pc;
      drop_cnt_d = outstanding_q - OW'(imem_rsp_valid);
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + STEP;
      if (push) rsp_pc_d   = rsp_pc_q + STEP;
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= PC_START;
      rsp_pc_q      <= PC_START;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      run_q         <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign wr_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (reset_n),
    .flush_i(E_redirect_valid),
    .push_i (push),
    .wdata_i(wr_entry),
    .pop_i  (pop),
    .rdata_o(rd_entry),
    .empty_o(q_empty),
    .full_o (q_full),
    .count_o(count)
  );

  assign F_valid      = !q_empty;
  assign F_instr      = F_valid ? rd_entry.instr : '0;
  assign F_pc_current = F_valid ? rd_entry.pc : '0;
  assign F_pc_plus_4  = F_pc_current + STEP;

  a_rsp_expected: assert property (@(posedge clk) disable iff (!reset_n)
                    imem_rsp_valid |-> (outstanding_q != '0));
  a_drop_bound:   assert property (@(posedge clk) disable iff (!reset_n)
                    drop_cnt_q <= outstanding_q);
  a_credit_full:  assert property (@(posedge clk) disable iff (!reset_n)
                    q_full |-> !imem_req_valid);
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus randomized traffic against a queue-level model.
module tb_fetch_queue_unit;
  localparam logic [31:0] PC_START = 32'h8000_0000;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0, reset_n = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        E_redirect_valid = 1'b0;
  logic [31:0] E_redirect_pc = '0;
  logic        F_valid, F_ready = 1'b0;
  logic [31:0] F_instr, F_pc_current, F_pc_plus_4, pc;

  int errors = 0;
  int checks = 0;

  // Memory side: addresses issued but not yet answered, and whether each is stale.
  logic [31:0] pend_addr[$];
  bit          pend_drop[$];
  // Model of the instruction queue (PCs; the word is a function of the PC).
  logic [31:0] mq_pc[$];
  logic [31:0] m_fetch;

  logic        o_rv, o_fv;
  logic [31:0] o_addr, o_pc, o_fpc, o_finstr, o_fpc4;
  bit          e_rv, e_fv;
  logic [31:0] e_addr, e_fpc, e_finstr;

  fetch_queue_unit dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .E_redirect_valid(E_redirect_valid), .E_redirect_pc(E_redirect_pc),
    .F_valid(F_valid), .F_ready(F_ready), .F_instr(F_instr),
    .F_pc_current(F_pc_current), .F_pc_plus_4(F_pc_plus_4), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h0019_660D + 32'h3C6E_F35F;
  endfunction

  // Drive one cycle at the falling edge, sample the DUT, then advance the model across the rising edge.
  task automatic tick(input bit rdy, input bit rsp, input bit fr, input bit rd, input logic [31:0] tgt);
    logic [31:0] a;
    bit d, rv;
    @(negedge clk);
    rv = rsp && (pend_addr.size() != 0);
    imem_req_ready   = rdy;
    imem_rsp_valid   = rv;
    imem_rsp_data    = rv ? mem_word(pend_addr[0]) : 32'hDEAD_BEEF;
    F_ready          = fr;
    E_redirect_valid = rd;
    E_redirect_pc    = tgt;
    #1;
    o_rv = imem_req_valid; o_addr = imem_req_addr; o_pc = pc; o_fv = F_valid;
    o_fpc = F_pc_current; o_finstr = F_instr; o_fpc4 = F_pc_plus_4;
    e_rv     = !rd && (pend_addr.size() < MAXO) && (pend_addr.size() + mq_pc.size() < DEPTH);
    e_addr   = m_fetch;
    e_fv     = (mq_pc.size() != 0);
    e_fpc    = e_fv ? mq_pc[0] : 32'h0;
    e_finstr = e_fv ? mem_word(mq_pc[0]) : 32'h0;
    a = '0; d = 1'b0;
    if (rv) begin
      a = pend_addr.pop_front();
      d = pend_drop.pop_front();
    end
    if (rd) begin
      mq_pc.delete();
      foreach (pend_drop[i]) pend_drop[i] = 1'b1;
      m_fetch = tgt;
    end else begin
      if (fr && e_fv) void'(mq_pc.pop_front());
      if (rv && !d) mq_pc.push_back(a);
      if (e_rv && rdy) begin
        pend_addr.push_back(m_fetch);
        pend_drop.push_back(1'b0);
        m_fetch = m_fetch + 32'd4;
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; F_ready = 1'b0;
    E_redirect_valid = 1'b0; E_redirect_pc = '0;
    pend_addr.delete(); pend_drop.delete(); mq_pc.delete();
    m_fetch = PC_START;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; E_redirect_valid = 1'b0; F_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    checks++; if (F_valid !== 1'b0) begin errors++; $display("FAIL reset_F_valid got=%b exp=0", F_valid); end
    checks++; if (F_instr !== 32'h0) begin errors++; $display("FAIL reset_F_instr got=%h exp=0", F_instr); end
    checks++; if (F_pc_current !== 32'h0) begin errors++; $display("FAIL reset_F_pc got=%h exp=0", F_pc_current); end
    checks++; if (F_pc_plus_4 !== 32'h4) begin errors++; $display("FAIL reset_F_pc4 got=%h exp=4", F_pc_plus_4); end
    checks++; if (pc !== PC_START || imem_req_addr !== PC_START) begin
      errors++; $display("FAIL reset_pc got=%h/%h exp=%h", pc, imem_req_addr, PC_START); end
    imem_req_ready = 1'b0;
    pend_addr.delete(); pend_drop.delete(); mq_pc.delete();
    m_fetch = PC_START;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== PC_START) begin
      errors++; $display("FAIL first_request got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, PC_START); end
  endtask

  task automatic test_stream();
    int nfire = 0, npop = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick(1, 1, 1, 0, 32'h0);
      if (o_rv) begin
        checks++; if (o_addr !== PC_START + 32'(4 * nfire)) begin
          errors++; $display("FAIL stream_addr got=%h exp=%h", o_addr, PC_START + 32'(4 * nfire)); end
        nfire++;
      end
      if (o_fv) begin
        checks++; if (o_fpc !== PC_START + 32'(4 * npop) || o_finstr !== mem_word(PC_START + 32'(4 * npop))) begin
          errors++; $display("FAIL stream_head got=%h:%h exp=%h", o_fpc, o_finstr, PC_START + 32'(4 * npop)); end
        npop++;
      end
    end
    checks++; if (nfire != 10) begin errors++; $display("FAIL stream_fires got=%0d exp=10", nfire); end
    checks++; if (npop != 8) begin errors++; $display("FAIL stream_pops got=%0d exp=8", npop); end
  endtask

  task automatic test_stall_full();
    int nfire = 0, npop = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick(1, 1, 0, 0, 32'h0);
      checks++; if (o_rv !== e_rv) begin errors++; $display("FAIL full_req_valid cyc=%0d got=%b exp=%b", c, o_rv, e_rv); end
      if (o_rv) nfire++;
    end
    checks++; if (nfire != 4) begin errors++; $display("FAIL full_fires got=%0d exp=4", nfire); end
    for (int c = 0; c < 6; c++) begin
      tick(0, 1, 1, 0, 32'h0);
      if (o_fv) begin
        checks++; if (o_fpc !== PC_START + 32'(4 * npop)) begin
          errors++; $display("FAIL drain_pc got=%h exp=%h", o_fpc, PC_START + 32'(4 * npop)); end
        npop++;
      end
    end
    checks++; if (npop != 4) begin errors++; $display("FAIL drain_count got=%0d exp=4", npop); end
  endtask

  task automatic test_req_stall();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick(0, 0, 0, 0, 32'h0);
      checks++; if (o_rv !== 1'b1 || o_addr !== PC_START) begin
        errors++; $display("FAIL hold_addr cyc=%0d got=%b/%h exp=1/%h", c, o_rv, o_addr, PC_START); end
    end
    tick(1, 0, 0, 0, 32'h0);
    checks++; if (o_rv !== 1'b1 || o_addr !== PC_START) begin
      errors++; $display("FAIL hold_fire got=%b/%h exp=1/%h", o_rv, o_addr, PC_START); end
    tick(0, 0, 0, 0, 32'h0);
    checks++; if (o_addr !== PC_START + 32'd4) begin errors++; $display("FAIL hold_after got=%h exp=%h", o_addr, PC_START + 32'd4); end
  endtask

  task automatic test_redirect_drop();
    bit found = 1'b0;
    do_reset();
    tick(1, 0, 0, 0, 32'h0);
    tick(1, 0, 0, 0, 32'h0);
    tick(0, 1, 0, 1, 32'h8000_0100);
    checks++; if (o_rv !== 1'b0) begin errors++; $display("FAIL redir_req_valid got=%b exp=0", o_rv); end
    #1;
    checks++; if (dut.drop_cnt_q !== 1) begin errors++; $display("FAIL redir_drop_cnt got=%0d exp=1", dut.drop_cnt_q); end
    tick(0, 1, 0, 0, 32'h0);
    checks++; if (o_fv !== 1'b0) begin errors++; $display("FAIL redir_stale got=%b exp=0", o_fv); end
    for (int c = 0; c < 10 && !found; c++) begin
      tick(1, 1, 0, 0, 32'h0);
      found = o_fv;
    end
    checks++; if (!found || o_fpc !== 32'h8000_0100 || o_finstr !== mem_word(32'h8000_0100)) begin
      errors++; $display("FAIL redir_first_head got=%b/%h:%h exp=1/80000100", found, o_fpc, o_finstr); end
  endtask

  task automatic test_redirect_full();
    do_reset();
    for (int c = 0; c < 8; c++) tick(1, 1, 0, 0, 32'h0);
    tick(1, 0, 1, 1, 32'h0000_0200);
    checks++; if (o_fv !== 1'b1 || o_rv !== 1'b0) begin
      errors++; $display("FAIL rfull_during got=%b/%b exp=1/0", o_fv, o_rv); end
    tick(0, 0, 0, 0, 32'h0);
    checks++; if (o_fv !== 1'b0) begin errors++; $display("FAIL rfull_flushed got=%b exp=0", o_fv); end
    checks++; if (o_rv !== 1'b1 || o_addr !== 32'h0000_0200) begin
      errors++; $display("FAIL rfull_target got=%b/%h exp=1/00000200", o_rv, o_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(0, 0, 0, 1, 32'hFFFF_FFFC);
    tick(1, 0, 0, 0, 32'h0);
    checks++; if (o_rv !== 1'b1 || o_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_fire got=%b/%h exp=1/fffffffc", o_rv, o_addr); end
    tick(0, 1, 0, 0, 32'h0);
    checks++; if (o_addr !== 32'h0 || o_pc !== 32'h0) begin
      errors++; $display("FAIL wrap_next got=%h/%h exp=0", o_addr, o_pc); end
    tick(0, 0, 0, 0, 32'h0);
    checks++; if (o_fv !== 1'b1 || o_fpc !== 32'hFFFF_FFFC || o_fpc4 !== 32'h0) begin
      errors++; $display("FAIL wrap_head got=%b/%h/%h exp=1/fffffffc/0", o_fv, o_fpc, o_fpc4); end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, tgt);
      checks++; if (o_rv !== e_rv) begin errors++; $display("FAIL rand_req_valid cyc=%0d got=%b exp=%b", c, o_rv, e_rv); end
      checks++; if (o_addr !== e_addr || o_pc !== e_addr) begin
        errors++; $display("FAIL rand_addr cyc=%0d got=%h/%h exp=%h", c, o_addr, o_pc, e_addr); end
      checks++; if (o_fv !== e_fv) begin errors++; $display("FAIL rand_F_valid cyc=%0d got=%b exp=%b", c, o_fv, e_fv); end
      checks++; if (o_fpc !== e_fpc || o_finstr !== e_finstr) begin
        errors++; $display("FAIL rand_head cyc=%0d got=%h:%h exp=%h:%h", c, o_fpc, o_finstr, e_fpc, e_finstr); end
      checks++; if (o_fpc4 !== e_fpc + 32'd4) begin
        errors++; $display("FAIL rand_pc4 cyc=%0d got=%h exp=%h", c, o_fpc4, e_fpc + 32'd4); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_full();
    test_req_stall();
    test_redirect_drop();
    test_redirect_full();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
